// File: rtl/key_entry_pkg.sv
// Shared key codes, FSM encoding and digit-buffer operations for the numeric key entry block.
package key_entry_pkg;

  localparam logic [4:0] KV_DIG_MIN = 5'd1;
  localparam logic [4:0] KV_DIG_MAX = 5'd10;
  localparam logic [4:0] KV_CLR     = 5'd11;
  localparam logic [4:0] KV_BKSP    = 5'd12;
  localparam logic [4:0] KV_ENT     = 5'd13;
  localparam logic [4:0] KV_ESC     = 5'd14;
  localparam logic [4:0] KV_MULT    = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    BOP_NONE = 3'd0,
    BOP_LOAD = 3'd1,
    BOP_SHL  = 3'd2,
    BOP_SHR  = 3'd3,
    BOP_CLR  = 3'd4
  } buf_op_t;

  function automatic logic is_digit_key(input logic [4:0] kv);
    return (kv >= KV_DIG_MIN) && (kv <= KV_DIG_MAX);
  endfunction

endpackage

// File: rtl/key_entry_ctrl_digit_buf.sv
// NDIG-nibble BCD shift register with digit count; ops take effect on the next clk.
// Latency 1 clk; no backpressure, the op input is acted on every cycle.
import key_entry_pkg::*;

module digit_buf #(
  parameter int NDIG = 4,
  localparam int CW  = $clog2(NDIG + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  buf_op_t           op,
  input  logic [3:0]        din,
  output logic [4*NDIG-1:0] buf_dat,
  output logic [CW-1:0]     cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_dat <= '0;
      cnt     <= '0;
    end else begin
      case (op)
        BOP_LOAD: begin
          buf_dat <= {{(4*NDIG-4){1'b0}}, din};
          cnt     <= CW'(1);
        end
        BOP_SHL: begin
          buf_dat <= {buf_dat[4*NDIG-5:0], din};
          cnt     <= cnt + CW'(1);
        end
        BOP_SHR: begin
          buf_dat <= {4'h0, buf_dat[4*NDIG-1:4]};
          cnt     <= cnt - CW'(1);
        end
        BOP_CLR: begin
          buf_dat <= '0;
          cnt     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/key_entry_ctrl.sv
// Key-scanner to BCD entry sequencer with valid/ready handoff; key effects visible 1 clk after nkpls.
// Backpressure: HOLD keeps val_valid until val_ready; optional inactivity timeout under ENTRY_TIMEOUT_EN.
import key_entry_pkg::*;

module key_entry_ctrl #(
  parameter int NDIG   = 4,
  parameter int TMO_MS = 5000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pls1k,
  input  logic              nkpls,
  input  logic [4:0]        nkv,
  output logic [4*NDIG-1:0] disp_dig,
  output logic [NDIG-1:0]   disp_blank,
  output logic [4*NDIG-1:0] val_data,
  output logic              val_valid,
  input  logic              val_ready,
  output logic              busy,
  output logic              err_pls
);

  localparam int CW = $clog2(NDIG + 1);

  state_t          state, nxt_state;
  buf_op_t         op;
  logic [4*NDIG-1:0] buf_dat;
  logic [CW-1:0]   cnt;
  logic            key_dig;
  logic [3:0]      key_val;
  logic            key_ok;
  logic            err_nxt;
  logic            val_ld;
  logic            val_clr;
  logic            tmo_hit;

  // Digit keys 1..10 map to values 0..9; nkv never exceeds 15 in that range.
  assign key_dig = is_digit_key(nkv);
  assign key_val = nkv[3:0] - 4'd1;

  digit_buf #(.NDIG(NDIG)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .op      (op),
    .din     (key_val),
    .buf_dat (buf_dat),
    .cnt     (cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    op        = BOP_NONE;
    err_nxt   = 1'b0;
    val_ld    = 1'b0;
    val_clr   = 1'b0;
    key_ok    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (nkpls) begin
          if (key_dig) begin
            op        = BOP_LOAD;
            nxt_state = ST_ENTRY;
          end else if (nkv != KV_CLR && nkv != KV_ESC && nkv != KV_BKSP) begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_ENTRY: begin
        if (nkpls) begin
          if (key_dig) begin
            if (cnt < CW'(NDIG)) begin
              op     = BOP_SHL;
              key_ok = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end else begin
            case (nkv)
              KV_BKSP: begin
                key_ok = 1'b1;
                if (cnt != '0) op = BOP_SHR;
                if (cnt <= CW'(1)) nxt_state = ST_IDLE;
              end
              KV_CLR: begin
                op     = BOP_CLR;
                key_ok = 1'b1;
              end
              KV_ESC: begin
                op        = BOP_CLR;
                nxt_state = ST_IDLE;
              end
              KV_ENT: begin
                if (cnt == '0) begin
                  err_nxt = 1'b1;
                end else begin
                  val_ld    = 1'b1;
                  nxt_state = ST_HOLD;
                end
              end
              default: err_nxt = 1'b1;
            endcase
          end
        end else if (tmo_hit) begin
          op        = BOP_CLR;
          nxt_state = ST_IDLE;
          err_nxt   = 1'b1;
        end
      end
      ST_HOLD: begin
        err_nxt = nkpls;
        if (val_valid && val_ready) begin
          op        = BOP_CLR;
          val_clr   = 1'b1;
          nxt_state = ST_IDLE;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_pls   <= 1'b0;
      val_valid <= 1'b0;
      val_data  <= '0;
    end else begin
      err_pls <= err_nxt;
      if (val_ld) begin
        val_valid <= 1'b1;
        val_data  <= buf_dat;
      end else if (val_clr) begin
        val_valid <= 1'b0;
      end
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TMO_MS + 1);
  logic          pls_d;
  logic          pls_edge;
  logic [TW-1:0] tmo_cnt;

  assign pls_edge = pls1k & ~pls_d;
  assign tmo_hit  = (state == ST_ENTRY) && pls_edge && (tmo_cnt == TW'(TMO_MS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pls_d   <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      pls_d <= pls1k;
      if (state != ST_ENTRY || nxt_state != ST_ENTRY || key_ok) tmo_cnt <= '0;
      else if (pls_edge) tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  logic unused_cfg;
  assign tmo_hit    = 1'b0;
  assign unused_cfg = ^{pls1k, key_ok, (TMO_MS > 0)};
`endif

  assign disp_dig = buf_dat;
  assign busy     = (state != ST_IDLE);

  always_comb begin
    disp_blank = '1;
    for (int i = 0; i < NDIG; i++) begin
      disp_blank[i] = (state == ST_IDLE) || (CW'(i) >= cnt);
    end
  end

endmodule
